// File: rtl/cpu_mc_pkg.sv
// rtl/cpu_mc_pkg.sv - shared loader state encoding, header field layout and memory depth
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    DRAIN = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } loader_state_e;

  localparam int HDR_BASE_MSB      = 31;
  localparam int HDR_BASE_LSB      = 16;
  localparam int HDR_CNT_MSB       = 15;
  localparam int HDR_CNT_LSB       = 0;
  localparam int MEM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: header-delimited word stream into CPU memory, then CPU release
module program_loader
  import cpu_mc_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  loader_state_e state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] idx_q, idx_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] words_q, words_d;

  logic [15:0] hdr_base;
  logic [15:0] hdr_cnt;
  logic [16:0] hdr_end;
  logic        accept;

  assign hdr_base = in_data[HDR_BASE_MSB:HDR_BASE_LSB];
  assign hdr_cnt  = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
  // 17-bit end index so a base near 0xFFFF cannot wrap past the bound
  assign hdr_end  = {1'b0, hdr_base} + {1'b0, hdr_cnt};

  assign in_ready = (state_q == HDR) || (state_q == DATA);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    case (state_q)
      HDR: begin
        if (accept) begin
          if (hdr_cnt == 16'd0) begin
            state_d = DRAIN;
          end else if (hdr_end > 17'(MEM_WORDS)) begin
            state_d = ERROR;
          end else begin
            state_d     = DATA;
            idx_d       = hdr_base;
            remaining_d = hdr_cnt;
          end
        end
      end
      DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {14'd0, idx_q, 2'b00};
          mem_wdata_d = in_data;
          idx_d       = idx_q + 16'd1;
          remaining_d = remaining_q - 16'd1;
          if (words_q != 16'hFFFF) begin
            words_d = words_q + 16'd1;
          end
          if (remaining_q == 16'd1) begin
            state_d = HDR;
          end
        end
      end
      DRAIN:   state_d = RUN;
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR;
      remaining_q <= 16'd0;
      idx_q       <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      words_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      words_q     <= words_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;
  assign cpu_reset    = (state_q != RUN);
  assign done         = (state_q == RUN);
  assign error        = (state_q == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed-vector bench for program_loader with a write-capturing memory model
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem_model [0:1023];
  logic [31:0] wr_addrs [$];
  logic [31:0] prog [0:21];
  logic [31:0] arr  [0:11];

  program_loader #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem_model[mem_addr[11:2]] = mem_wdata;
      wr_addrs.push_back(mem_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'hDEAD_BEEF;
    wr_addrs.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 32'd0;
    @(posedge clk); #1;
    clear_model();
    reset = 1'b0;
  endtask

  // returns 1ns after the accepting edge
  task automatic send(input logic [31:0] w);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = w;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 22; i++) prog[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    arr[0] = 55; arr[1] = 88; arr[2] = 0;   arr[3] = 22;  arr[4] = 77;   arr[5] = 11;
    arr[6] = 99; arr[7] = 33; arr[8] = 110; arr[9] = 66;  arr[10] = 121; arr[11] = 44;

    // reset values
    do_reset();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);

    // full bubble-sort load
    send(32'h0000_0016);
    check_eq("hdr_no_write", 32'(mem_we), 32'd0);
    for (int i = 0; i < 22; i++) send(prog[i]);
    check_eq("prog_last_we", 32'(mem_we), 32'd1);
    check_eq("prog_last_addr", mem_addr, 32'd84);
    send(32'h0080_000C);
    for (int i = 0; i < 12; i++) send(arr[i]);
    send(32'h0000_0000);
    check_eq("drain_done", 32'(done), 32'd0);
    check_eq("drain_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("run_done", 32'(done), 32'd1);
    check_eq("run_cpu_reset", 32'(cpu_reset), 32'd0);
    check_eq("bs_words", 32'(words_loaded), 32'd34);
    check_eq("bs_wr_count", 32'(wr_addrs.size()), 32'd34);
    for (int i = 0; i < 22; i++) check_eq($sformatf("prog_mem[%0d]", i), mem_model[i], prog[i]);
    for (int i = 0; i < 12; i++) check_eq($sformatf("arr_mem[%0d]", i), mem_model[128 + i], arr[i]);

    // stream presented after done
    in_valid = 1'b1;
    in_data = 32'h0000_0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("run_in_ready", 32'(in_ready), 32'd0);
      check_eq("run_no_we", 32'(mem_we), 32'd0);
      check_eq("run_done_hold", 32'(done), 32'd1);
    end
    in_valid = 1'b0;

    // backpressure gap mid-segment
    do_reset();
    send(32'h0080_0004);
    send(32'h0000_0A01);
    send(32'h0000_0A02);
    check_eq("bp_pre_gap_we", 32'(mem_we), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("bp_gap_we", 32'(mem_we), 32'd0);
    end
    send(32'h0000_0A03);
    send(32'h0000_0A04);
    send(32'h0000_0000);
    @(posedge clk); #1;
    check_eq("bp_done", 32'(done), 32'd1);
    check_eq("bp_wr_count", 32'(wr_addrs.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addrs.size()) check_eq("bp_addr", wr_addrs[i], 32'd512 + 32'(4 * i));
      check_eq("bp_mem", mem_model[128 + i], 32'h0000_0A01 + 32'(i));
    end

    // segment ending exactly at the top of memory is legal
    do_reset();
    send(32'h03FC_0004);
    for (int i = 0; i < 4; i++) send(32'h5555_0000 + 32'(i));
    send(32'h0000_0000);
    @(posedge clk); #1;
    check_eq("edge_error", 32'(error), 32'd0);
    check_eq("edge_done", 32'(done), 32'd1);
    check_eq("edge_mem_top", mem_model[1023], 32'h5555_0003);

    // overflowing header
    do_reset();
    send(32'h03FC_0008);
    check_eq("ovf_error", 32'(error), 32'd1);
    check_eq("ovf_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("ovf_no_we", 32'(mem_we), 32'd0);
      check_eq("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
      check_eq("ovf_done", 32'(done), 32'd0);
    end
    in_valid = 1'b0;
    check_eq("ovf_wr_count", 32'(wr_addrs.size()), 32'd0);

    // immediate terminator
    do_reset();
    send(32'h0000_0000);
    check_eq("imm_done_t", 32'(done), 32'd0);
    @(posedge clk); #1;
    check_eq("imm_done_t1", 32'(done), 32'd1);
    check_eq("imm_wr_count", 32'(wr_addrs.size()), 32'd0);

    // reset in the middle of a segment
    do_reset();
    send(32'h0000_000A);
    for (int i = 0; i < 5; i++) send(32'h7000_0000 + 32'(i));
    check_eq("mid_words", 32'(words_loaded), 32'd5);
    do_reset();
    check_eq("mid_we", 32'(mem_we), 32'd0);
    check_eq("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("mid_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_words_rst", 32'(words_loaded), 32'd0);
    send(32'h0010_0001);
    check_eq("mid_hdr_no_we", 32'(mem_we), 32'd0);
    send(32'h0000_CAFE);
    check_eq("mid_new_we", 32'(mem_we), 32'd1);
    check_eq("mid_new_addr", mem_addr, 32'h0000_0040);
    check_eq("mid_new_data", mem_wdata, 32'h0000_CAFE);
    check_eq("mid_new_words", 32'(words_loaded), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
